// File: rtl/icache_fetch_responder_if.sv
// Bundle of the fetch-side request/response signals and the memory AR/R read channel.
// The slave modport is the responder's view; the master modport is the environment's view.
interface icache_fetch_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        linebuf_inv;
  logic        arvalid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arready;
  logic        rvalid;
  logic [31:0] rdata;
  logic        rlast;
  logic        rready;

  modport slave (
    input  req, addr, linebuf_inv, arready, rvalid, rdata, rlast,
    output addr_ok, data_ok, rdata1, rdata2, arvalid, araddr, arlen, arsize, rready
  );

  modport master (
    output req, addr, linebuf_inv, arready, rvalid, rdata, rlast,
    input  addr_ok, data_ok, rdata1, rdata2, arvalid, araddr, arlen, arsize, rready
  );
endinterface

// File: rtl/icache_fetch_responder.sv
// Dual-word fetch responder: each accepted fetch becomes a 2-beat read burst, returned as one data_ok.
// Optional single-line buffer is built when ICACHE_RESP_LINEBUF_EN is defined.
module icache_fetch_responder #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  icache_fetch_responder_if.slave bus
);

  typedef enum logic {
    BEAT_FIRST  = 1'b0,
    BEAT_SECOND = 1'b1
  } beat_e;

  localparam logic [2:0] MaxOut = 3'(MAX_OUTSTANDING);

  beat_e       beat_q, beat_d;
  logic [2:0]  outCnt_q, outCnt_d;
  logic        arValid_q, arValid_d;
  logic [31:0] arAddr_q, arAddr_d;
  logic [31:0] word0Hold_q, word0Hold_d;
  logic        dataOk_q, dataOk_d;
  logic        fromBuf_q, fromBuf_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] rdata2_q, rdata2_d;

  logic        rReady;
  logic        rAccept;
  logic        addrOk;
  logic        memAccept;
  logic        memDone;
  logic        bufHit;
  logic [31:0] bufWord0;
  logic [31:0] bufWord1;

  assign rReady  = !reset;
  assign rAccept = bus.rvalid && rReady;
  // Buffer hits also pulse data_ok but never owned an outstanding slot.
  assign memDone = dataOk_q && !fromBuf_q;

`ifdef ICACHE_RESP_LINEBUF_EN
  logic        lbValid_q;
  logic [28:0] lbTag_q;
  logic [31:0] lbWord0_q;
  logic [31:0] lbWord1_q;
  logic [28:0] tagFifo_q [8];
  logic [2:0]  tagWr_q;
  logic [2:0]  tagRd_q;

  assign bufHit   = bus.req && lbValid_q && (lbTag_q == bus.addr[31:3])
                    && (outCnt_q == 3'd0) && !arValid_q;
  assign bufWord0 = lbWord0_q;
  assign bufWord1 = lbWord1_q;

  // Line tags of in-flight bursts, so a completing burst knows which line it refills.
  always_ff @(posedge clk) begin
    if (memAccept) begin
      tagFifo_q[tagWr_q] <= bus.addr[31:3];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lbValid_q <= 1'b0;
      lbTag_q   <= '0;
      lbWord0_q <= '0;
      lbWord1_q <= '0;
      tagWr_q   <= '0;
      tagRd_q   <= '0;
    end else begin
      if (memAccept) begin
        tagWr_q <= tagWr_q + 3'd1;
      end
      if (memDone) begin
        tagRd_q   <= tagRd_q + 3'd1;
        lbTag_q   <= tagFifo_q[tagRd_q];
        lbWord0_q <= rdata1_q;
        lbWord1_q <= rdata2_q;
      end
      if (bus.linebuf_inv) begin
        lbValid_q <= 1'b0;
      end else if (memDone) begin
        lbValid_q <= 1'b1;
      end
    end
  end

  logic unused_addrBits;
  assign unused_addrBits = ^bus.addr[2:0];
`else
  assign bufHit   = 1'b0;
  assign bufWord0 = '0;
  assign bufWord1 = '0;

  logic unused_inputs;
  assign unused_inputs = ^{bus.addr[2:0], bus.linebuf_inv};
`endif

  always_comb begin
    addrOk    = (bus.req && (!arValid_q || bus.arready) && (outCnt_q < MaxOut)) || bufHit;
    memAccept = addrOk && !bufHit;
    arValid_d = arValid_q;
    arAddr_d  = arAddr_q;
    if (memAccept) begin
      arValid_d = 1'b1;
      arAddr_d  = {bus.addr[31:3], 3'b000};
    end else if (bus.arready) begin
      arValid_d = 1'b0;
    end
    outCnt_d = outCnt_q;
    if (memAccept && !memDone) begin
      outCnt_d = outCnt_q + 3'd1;
    end else if (!memAccept && memDone) begin
      outCnt_d = outCnt_q - 3'd1;
    end
  end

  always_comb begin
    beat_d      = beat_q;
    word0Hold_d = word0Hold_q;
    dataOk_d    = 1'b0;
    fromBuf_d   = 1'b0;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    if (rAccept) begin
      case (beat_q)
        BEAT_FIRST: begin
          word0Hold_d = bus.rdata;
          beat_d      = BEAT_SECOND;
          if (bus.rlast) begin
            beat_d   = BEAT_FIRST;
            dataOk_d = 1'b1;
            rdata1_d = bus.rdata;
            rdata2_d = '0;
          end
        end
        BEAT_SECOND: begin
          beat_d = BEAT_FIRST;
          if (bus.rlast) begin
            dataOk_d = 1'b1;
            rdata1_d = word0Hold_q;
            rdata2_d = bus.rdata;
          end
        end
        default: beat_d = BEAT_FIRST;
      endcase
    end else if (bufHit) begin
      dataOk_d  = 1'b1;
      fromBuf_d = 1'b1;
      rdata1_d  = bufWord0;
      rdata2_d  = bufWord1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_q      <= BEAT_FIRST;
      outCnt_q    <= '0;
      arValid_q   <= 1'b0;
      arAddr_q    <= '0;
      word0Hold_q <= '0;
      dataOk_q    <= 1'b0;
      fromBuf_q   <= 1'b0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
    end else begin
      beat_q      <= beat_d;
      outCnt_q    <= outCnt_d;
      arValid_q   <= arValid_d;
      arAddr_q    <= arAddr_d;
      word0Hold_q <= word0Hold_d;
      dataOk_q    <= dataOk_d;
      fromBuf_q   <= fromBuf_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
    end
  end

  assign bus.addr_ok = addrOk;
  assign bus.data_ok = dataOk_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.rdata2  = rdata2_q;
  assign bus.arvalid = arValid_q;
  assign bus.araddr  = arAddr_q;
  assign bus.arlen   = 8'd1;
  assign bus.arsize  = 3'd2;
  assign bus.rready  = rReady;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Directed bench for icache_fetch_responder: a queue-based reference model checked on every cycle,
// plus hand-computed spot checks that pin the model. Define ICACHE_RESP_LINEBUF_EN to cover the line buffer.
module tb_icache_fetch_responder;

  localparam int MaxOut = 2;
  localparam logic [31:0] Z = 32'd0;

  logic clk;
  logic reset;

  icache_fetch_responder_if bus();

  icache_fetch_responder #(
    .MAX_OUTSTANDING(MaxOut)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: pending AR addresses, line tags of in-flight bursts, beats of the current burst.
  logic [31:0] arQ[$];
  logic [28:0] tagQ[$];
  logic [31:0] beatQ[$];
  int          mOut;
  logic        started;
  logic        expDataOk;
  logic        expFromMem;
  logic [31:0] expR1;
  logic [31:0] expR2;
  logic        lbValid;
  logic [28:0] lbTag;
  logic [31:0] lbW0;
  logic [31:0] lbW1;
  logic        hit;
  logic        expAddrOk;
  logic        nextOk;
  logic        nextMem;
  logic [28:0] doneTag;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drives one cycle's worth of inputs just after the rising edge.
  task automatic applyStimulus(input logic rst, input logic rq, input logic [31:0] ad, input logic arr,
                               input logic rv, input logic [31:0] rd, input logic rl, input logic inv);
    @(posedge clk);
    #1;
    reset           = rst;
    bus.req         = rq;
    bus.addr        = ad;
    bus.arready     = arr;
    bus.rvalid      = rv;
    bus.rdata       = rd;
    bus.rlast       = rl;
    bus.linebuf_inv = inv;
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, Z, 1, 0, Z, 0, 0);
  endtask

  // Model: compare this cycle's outputs, then advance to what the next cycle must show.
  always @(negedge clk) begin
    if (reset) begin
      if (started) checkOutput("rready_in_reset", {31'd0, bus.rready}, 32'd0);
      started    = 1'b1;
      arQ.delete();
      tagQ.delete();
      beatQ.delete();
      mOut       = 0;
      expDataOk  = 1'b0;
      expFromMem = 1'b0;
      expR1      = '0;
      expR2      = '0;
      lbValid    = 1'b0;
    end else if (started) begin
      hit = 1'b0;
`ifdef ICACHE_RESP_LINEBUF_EN
      hit = bus.req && lbValid && (lbTag == bus.addr[31:3]) && (mOut == 0) && (arQ.size() == 0);
`endif
      expAddrOk = (bus.req && ((arQ.size() == 0) || bus.arready) && (mOut < MaxOut)) || hit;
      checkOutput("model_addr_ok", {31'd0, bus.addr_ok}, {31'd0, expAddrOk});
      checkOutput("model_arvalid", {31'd0, bus.arvalid}, {31'd0, arQ.size() != 0});
      if (arQ.size() != 0) begin
        checkOutput("model_araddr", bus.araddr, arQ[0]);
        checkOutput("model_arlen", {24'd0, bus.arlen}, 32'd1);
        checkOutput("model_arsize", {29'd0, bus.arsize}, 32'd2);
      end
      checkOutput("model_data_ok", {31'd0, bus.data_ok}, {31'd0, expDataOk});
      checkOutput("model_rdata1", bus.rdata1, expR1);
      checkOutput("model_rdata2", bus.rdata2, expR2);
      checkOutput("model_rready", {31'd0, bus.rready}, 32'd1);

      if (expDataOk && expFromMem) begin
        doneTag = tagQ.pop_front();
        mOut    = mOut - 1;
        lbValid = 1'b1;
        lbTag   = doneTag;
        lbW0    = expR1;
        lbW1    = expR2;
      end
      if (bus.linebuf_inv) lbValid = 1'b0;
      if ((arQ.size() != 0) && bus.arready) void'(arQ.pop_front());
      if (expAddrOk && !hit) begin
        arQ.push_back({bus.addr[31:3], 3'b000});
        tagQ.push_back(bus.addr[31:3]);
        mOut = mOut + 1;
      end

      nextOk  = 1'b0;
      nextMem = 1'b0;
      if (bus.rvalid) begin
        beatQ.push_back(bus.rdata);
        if (bus.rlast) begin
          nextOk  = 1'b1;
          nextMem = 1'b1;
          expR1   = beatQ[0];
          expR2   = (beatQ.size() > 1) ? beatQ[1] : 32'd0;
          beatQ.delete();
        end
      end else if (hit) begin
        nextOk = 1'b1;
        expR1  = lbW0;
        expR2  = lbW1;
      end
      expDataOk  = nextOk;
      expFromMem = nextMem;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    started         = 1'b0;
    reset           = 1'b1;
    bus.req         = 1'b0;
    bus.addr        = '0;
    bus.arready     = 1'b0;
    bus.rvalid      = 1'b0;
    bus.rdata       = '0;
    bus.rlast       = 1'b0;
    bus.linebuf_inv = 1'b0;
    applyStimulus(1, 0, Z, 0, 0, Z, 0, 0);

    idleCycle();
    @(negedge clk);
    checkOutput("reset_data_ok", {31'd0, bus.data_ok}, 32'd0);
    checkOutput("reset_arvalid", {31'd0, bus.arvalid}, 32'd0);
    checkOutput("reset_araddr", bus.araddr, 32'd0);
    checkOutput("reset_rdata1", bus.rdata1, 32'd0);
    checkOutput("reset_rdata2", bus.rdata2, 32'd0);
    checkOutput("reset_rready", {31'd0, bus.rready}, 32'd1);

    // Basic read
    applyStimulus(0, 1, 32'h1FC0_0004, 0, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t1_addr_ok", {31'd0, bus.addr_ok}, 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("t1_arvalid", {31'd0, bus.arvalid}, 32'd1);
    checkOutput("t1_araddr", bus.araddr, 32'h1FC0_0000);
    checkOutput("t1_arlen", {24'd0, bus.arlen}, 32'd1);
    applyStimulus(0, 0, Z, 1, 1, 32'h1111_1111, 0, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'h2222_2222, 1, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t1_data_ok", {31'd0, bus.data_ok}, 32'd1);
    checkOutput("t1_rdata1", bus.rdata1, 32'h1111_1111);
    checkOutput("t1_rdata2", bus.rdata2, 32'h2222_2222);
    idleCycle();
    @(negedge clk);
    checkOutput("t1_data_ok_pulse", {31'd0, bus.data_ok}, 32'd0);
    checkOutput("t1_rdata1_hold", bus.rdata1, 32'h1111_1111);

    // Outstanding limit
    applyStimulus(0, 1, 32'h0000_0200, 1, 0, Z, 0, 0);
    applyStimulus(0, 1, 32'h0000_0208, 1, 0, Z, 0, 0);
    applyStimulus(0, 1, 32'h0000_0210, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t2_third_blocked", {31'd0, bus.addr_ok}, 32'd0);
    applyStimulus(0, 1, 32'h0000_0210, 1, 1, 32'h0000_200A, 0, 0);
    applyStimulus(0, 1, 32'h0000_0210, 1, 1, 32'h0000_200B, 1, 0);
    applyStimulus(0, 1, 32'h0000_0210, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t2_data_ok_a", {31'd0, bus.data_ok}, 32'd1);
    checkOutput("t2_rdata1_a", bus.rdata1, 32'h0000_200A);
    checkOutput("t2_blocked_at_data_ok", {31'd0, bus.addr_ok}, 32'd0);
    applyStimulus(0, 1, 32'h0000_0210, 1, 1, 32'h0000_208A, 0, 0);
    @(negedge clk);
    checkOutput("t2_third_accepted", {31'd0, bus.addr_ok}, 32'd1);
    applyStimulus(0, 0, Z, 1, 1, 32'h0000_208B, 1, 0);
    @(negedge clk);
    checkOutput("t2_araddr_c", bus.araddr, 32'h0000_0210);
    applyStimulus(0, 0, Z, 1, 1, 32'h0000_210A, 0, 0);
    @(negedge clk);
    checkOutput("t2_rdata2_b", bus.rdata2, 32'h0000_208B);
    applyStimulus(0, 0, Z, 1, 1, 32'h0000_210B, 1, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t2_rdata1_c", bus.rdata1, 32'h0000_210A);
    checkOutput("t2_rdata2_c", bus.rdata2, 32'h0000_210B);

    // AR stall
    applyStimulus(0, 1, 32'h0000_0300, 0, 0, Z, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 32'h0000_0308, 0, 0, Z, 0, 0);
      @(negedge clk);
      checkOutput("t3_stall_addr_ok", {31'd0, bus.addr_ok}, 32'd0);
      checkOutput("t3_stall_araddr", bus.araddr, 32'h0000_0300);
    end
    applyStimulus(0, 1, 32'h0000_0308, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t3_release_addr_ok", {31'd0, bus.addr_ok}, 32'd1);
    applyStimulus(0, 0, Z, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t3_next_araddr", bus.araddr, 32'h0000_0308);
    applyStimulus(0, 0, Z, 1, 1, 32'h3000_0001, 0, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'h3000_0002, 1, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'h3080_0001, 0, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'h3080_0002, 1, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t3_rdata1_second", bus.rdata1, 32'h3080_0001);

    // Order and accept coinciding with data_ok
    applyStimulus(0, 1, 32'h0000_0100, 1, 0, Z, 0, 0);
    idleCycle();
    applyStimulus(0, 0, Z, 1, 1, 32'hA000_0000, 0, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'hA000_0001, 1, 0);
    applyStimulus(0, 1, 32'h0000_0108, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t4_data_ok_a", {31'd0, bus.data_ok}, 32'd1);
    checkOutput("t4_rdata1_a", bus.rdata1, 32'hA000_0000);
    checkOutput("t4_accept_b_same_cycle", {31'd0, bus.addr_ok}, 32'd1);
    applyStimulus(0, 1, 32'h0000_0110, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t4_accept_c", {31'd0, bus.addr_ok}, 32'd1);
    applyStimulus(0, 1, 32'h0000_0118, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t4_d_blocked", {31'd0, bus.addr_ok}, 32'd0);
    applyStimulus(0, 0, Z, 1, 1, 32'hB000_0000, 0, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'hB000_0001, 1, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'hC000_0000, 0, 0);
    @(negedge clk);
    checkOutput("t4_rdata1_b", bus.rdata1, 32'hB000_0000);
    checkOutput("t4_rdata2_b", bus.rdata2, 32'hB000_0001);
    applyStimulus(0, 0, Z, 1, 1, 32'hC000_0001, 1, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t4_data_ok_c", {31'd0, bus.data_ok}, 32'd1);
    checkOutput("t4_rdata1_c", bus.rdata1, 32'hC000_0000);

    // rlast on the first beat leaves the second word zero
    applyStimulus(0, 1, 32'h0000_0400, 1, 0, Z, 0, 0);
    idleCycle();
    applyStimulus(0, 0, Z, 1, 1, 32'h4040_4040, 1, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t_short_rdata1", bus.rdata1, 32'h4040_4040);
    checkOutput("t_short_rdata2", bus.rdata2, 32'h0000_0000);
    idleCycle();

`ifdef ICACHE_RESP_LINEBUF_EN
    // Line buffer hit, then invalidate forces a fresh AR
    applyStimulus(0, 1, 32'h0000_0100, 1, 0, Z, 0, 0);
    idleCycle();
    applyStimulus(0, 0, Z, 1, 1, 32'h5A5A_0001, 0, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'h5A5A_0002, 1, 0);
    idleCycle();
    applyStimulus(0, 1, 32'h0000_0104, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t5_hit_addr_ok", {31'd0, bus.addr_ok}, 32'd1);
    idleCycle();
    @(negedge clk);
    checkOutput("t5_hit_no_ar", {31'd0, bus.arvalid}, 32'd0);
    checkOutput("t5_hit_data_ok", {31'd0, bus.data_ok}, 32'd1);
    checkOutput("t5_hit_rdata1", bus.rdata1, 32'h5A5A_0001);
    checkOutput("t5_hit_rdata2", bus.rdata2, 32'h5A5A_0002);
    applyStimulus(0, 0, Z, 1, 0, Z, 0, 1);
    applyStimulus(0, 1, 32'h0000_0100, 1, 0, Z, 0, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t5_inv_arvalid", {31'd0, bus.arvalid}, 32'd1);
    checkOutput("t5_inv_araddr", bus.araddr, 32'h0000_0100);
    applyStimulus(0, 0, Z, 1, 1, 32'h5A5A_0003, 0, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'h5A5A_0004, 1, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t5_refill_rdata1", bus.rdata1, 32'h5A5A_0003);
    idleCycle();
`endif

    // Reset during the first beat of a burst
    applyStimulus(0, 1, 32'h0000_0600, 1, 0, Z, 0, 0);
    idleCycle();
    applyStimulus(1, 0, Z, 1, 1, 32'h6666_6666, 0, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t6_data_ok", {31'd0, bus.data_ok}, 32'd0);
    checkOutput("t6_arvalid", {31'd0, bus.arvalid}, 32'd0);
    checkOutput("t6_rdata1", bus.rdata1, 32'd0);
    applyStimulus(0, 1, 32'h0000_0608, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t6_accept_first", {31'd0, bus.addr_ok}, 32'd1);
    applyStimulus(0, 1, 32'h0000_0610, 1, 0, Z, 0, 0);
    @(negedge clk);
    checkOutput("t6_accept_second", {31'd0, bus.addr_ok}, 32'd1);
    applyStimulus(0, 0, Z, 1, 1, 32'h6080_0000, 0, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'h6080_0001, 1, 0);
    applyStimulus(0, 0, Z, 1, 1, 32'h6100_0000, 0, 0);
    @(negedge clk);
    checkOutput("t6_rdata1", bus.rdata1, 32'h6080_0000);
    checkOutput("t6_rdata2", bus.rdata2, 32'h6080_0001);
    applyStimulus(0, 0, Z, 1, 1, 32'h6100_0001, 1, 0);
    idleCycle();
    @(negedge clk);
    checkOutput("t6_rdata1_next", bus.rdata1, 32'h6100_0000);
    idleCycle();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
